// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-back arbiter for the single write port of the 8x8 register file.
// The ALU result path and the memory-load path each push into their own
// small FIFO through a valid/ready handshake. One FIFO head is granted per
// cycle and registered onto WR_EN/WR_ADDR/WR_DATA, which connect directly to
// the register file's WRITE/INADDRESS/IN. A pending-write scoreboard raises
// STALL when a decode read address matches any queued or in-flight write.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   ALU_VALID/ADDR/DATA   ALU write request          ALU_READY  ALU FIFO not full
//   MEM_VALID/ADDR/DATA   load write request         MEM_READY  MEM FIFO not full
//   WR_EN/WR_ADDR/WR_DATA registered register-file write port
//   RD1_ADDR, RD2_ADDR    decode read addresses      STALL      RAW hazard flag
//   PENDING               entries queued in both FIFOs (write stage excluded)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int PEND_W = $clog2(2 * DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ALU_VALID,
   input  logic [ADDR_W-1:0] ALU_ADDR,
   input  logic [DATA_W-1:0] ALU_DATA,
   output logic              ALU_READY,
   input  logic              MEM_VALID,
   input  logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [DATA_W-1:0] MEM_DATA,
   output logic              MEM_READY,
   output logic              WR_EN,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [DATA_W-1:0] WR_DATA,
   input  logic [ADDR_W-1:0] RD1_ADDR,
   input  logic [ADDR_W-1:0] RD2_ADDR,
   output logic              STALL,
   output logic [PEND_W-1:0] PENDING
);

   localparam int   PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int   CNT_W    = PTR_W + 1;
   localparam int   SEQ_W    = 4;
   localparam logic SIDE_ALU = 1'b0;
   localparam logic SIDE_MEM = 1'b1;

   // Index 0 is the ALU requester, index 1 the memory-load requester.
   logic [1:0]        req_valid;
   logic [1:0]        ready;
   logic [1:0]        push;
   logic [1:0]        grant;
   logic [1:0]        head_valid;
   logic [1:0]        fifo_hit;
   logic [ADDR_W-1:0] req_addr  [2];
   logic [DATA_W-1:0] req_data  [2];
   logic [ADDR_W-1:0] head_addr [2];
   logic [DATA_W-1:0] head_data [2];
   logic [SEQ_W-1:0]  head_seq  [2];
   logic [SEQ_W-1:0]  push_seq  [2];
   logic [CNT_W-1:0]  count     [2];

   logic              rr_ptr_reg, rr_ptr_next;
   logic [SEQ_W-1:0]  seq_reg, seq_next, seq_diff;
   logic              wr_en_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [DATA_W-1:0] wr_data_reg;

   assign req_valid   = {MEM_VALID, ALU_VALID};
   assign req_addr[0] = ALU_ADDR;
   assign req_addr[1] = MEM_ADDR;
   assign req_data[0] = ALU_DATA;
   assign req_data[1] = MEM_DATA;

   // Shared age stamp: on a simultaneous accept the ALU entry is the older one.
   assign push_seq[0] = seq_reg;
   assign push_seq[1] = seq_reg + SEQ_W'(push[0]);
   assign seq_next    = seq_reg + SEQ_W'(push[0]) + SEQ_W'(push[1]);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [ADDR_W-1:0] addr_mem [DEPTH];
         logic [DATA_W-1:0] data_mem [DEPTH];
         logic [SEQ_W-1:0]  seq_mem  [DEPTH];
         logic [PTR_W-1:0]  rd_ptr_reg;
         logic [PTR_W-1:0]  wr_ptr_reg;
         logic [CNT_W-1:0]  count_reg;
         logic [PTR_W-1:0]  offset;
         logic              hit;

         // Ready looks only at the occupancy before the edge, so a full FIFO
         // never takes a push even when it is being popped on the same edge.
         assign ready[gi]      = (count_reg < CNT_W'(DEPTH));
         assign push[gi]       = req_valid[gi] & ready[gi];
         assign head_valid[gi] = (count_reg != '0);
         assign head_addr[gi]  = addr_mem[rd_ptr_reg];
         assign head_data[gi]  = data_mem[rd_ptr_reg];
         assign head_seq[gi]   = seq_mem[rd_ptr_reg];
         assign count[gi]      = count_reg;
         assign fifo_hit[gi]   = hit;

         always_ff @(posedge CLK) begin
            if (push[gi]) begin
               addr_mem[wr_ptr_reg] <= req_addr[gi];
               data_mem[wr_ptr_reg] <= req_data[gi];
               seq_mem[wr_ptr_reg]  <= push_seq[gi];
            end
         end

         always_ff @(posedge CLK) begin
            if (RESET) begin
               rd_ptr_reg <= '0;
               wr_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push[gi])
                  wr_ptr_reg <= wr_ptr_reg + 1'b1;
               if (grant[gi])
                  rd_ptr_reg <= rd_ptr_reg + 1'b1;
               count_reg <= count_reg + CNT_W'(push[gi]) - CNT_W'(grant[gi]);
            end
         end

         // An entry is live when its distance from the read pointer is
         // below the occupancy count.
         always_comb begin
            hit    = 1'b0;
            offset = '0;
            for (int i = 0; i < DEPTH; i++) begin
               offset = PTR_W'(i) - rd_ptr_reg;
               if ((CNT_W'(offset) < count_reg) &&
                   ((addr_mem[i] == RD1_ADDR) || (addr_mem[i] == RD2_ADDR)))
                  hit = 1'b1;
            end
         end
      end
   endgenerate

   // Grant selection from the heads as they stood before this edge.
   // Equal destinations must retire in acceptance order, so age decides and
   // the round-robin pointer is left alone; otherwise round-robin applies.
   always_comb begin
      grant       = 2'b00;
      rr_ptr_next = rr_ptr_reg;
      seq_diff    = head_seq[0] - head_seq[1];
      if (head_valid[0] && head_valid[1]) begin
         if (head_addr[0] == head_addr[1]) begin
            // Negative wrapped difference means the ALU head is older.
            grant = seq_diff[SEQ_W-1] ? 2'b01 : 2'b10;
         end else if (rr_ptr_reg == SIDE_ALU) begin
            grant       = 2'b01;
            rr_ptr_next = SIDE_MEM;
         end else begin
            grant       = 2'b10;
            rr_ptr_next = SIDE_ALU;
         end
      end else begin
         grant = head_valid;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_en_reg   <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
         rr_ptr_reg  <= SIDE_ALU;
         seq_reg     <= '0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
         seq_reg    <= seq_next;
         wr_en_reg  <= |grant;
         // Address and data hold their last value on idle cycles.
         if (grant[1]) begin
            wr_addr_reg <= head_addr[1];
            wr_data_reg <= head_data[1];
         end else if (grant[0]) begin
            wr_addr_reg <= head_addr[0];
            wr_data_reg <= head_data[0];
         end
      end
   end

   assign ALU_READY = ready[0];
   assign MEM_READY = ready[1];
   assign WR_EN     = wr_en_reg;
   assign WR_ADDR   = wr_addr_reg;
   assign WR_DATA   = wr_data_reg;
   assign PENDING   = PEND_W'(count[0]) + PEND_W'(count[1]);
   assign STALL     = (|fifo_hit) ||
                      (wr_en_reg && ((wr_addr_reg == RD1_ADDR) || (wr_addr_reg == RD2_ADDR)));

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 8x8 register file between two write-back requesters: the ALU result path and the memory-load path.
- Each requester has a valid/ready handshake into its own 2-entry FIFO.
- The block drains one entry per cycle onto a registered write port, so it connects directly to the register file's IN/INADDRESS/WRITE.
- It also provides a pending-write scoreboard so the decode stage can stall on read-after-write hazards.

Parameters:
- DEPTH, 2, entries per requester FIFO (power of two, 2 or 4)
- DATA_W, 8, write data width
- ADDR_W, 3, register address width

Ports:
- CLK  in  1  clock, all state changes on posedge
- RESET  in  1  synchronous, active-high reset
- ALU_VALID  in  1  ALU write request valid
- ALU_ADDR  in  ADDR_W  ALU destination register
- ALU_DATA  in  DATA_W  ALU result
- ALU_READY  out  1  ALU FIFO not full
- MEM_VALID  in  1  load write request valid
- MEM_ADDR  in  ADDR_W  load destination register
- MEM_DATA  in  DATA_W  load data
- MEM_READY  out  1  MEM FIFO not full
- WR_EN  out  1  register file WRITE
- WR_ADDR  out  ADDR_W  register file INADDRESS
- WR_DATA  out  DATA_W  register file IN
- RD1_ADDR  in  ADDR_W  decode read address 1
- RD2_ADDR  in  ADDR_W  decode read address 2
- STALL  out  1  read address matches a pending write
- PENDING  out  3  total queued entries (0..2*DEPTH)

Behaviour:
- Reset (RESET high at posedge, takes priority over everything):
  - Both FIFOs emptied and age counter cleared.
  - WR_EN=0, WR_ADDR=0, WR_DATA=0, PENDING=0.
  - Round-robin pointer set to ALU; READY outputs read 1 on the following cycle.
  - A request presented in the reset cycle is dropped.
  - Reset mid-operation discards queued entries without writing them.
- Acceptance:
  - A request is accepted at a posedge when VALID && READY.
  - READY = FIFO count < DEPTH. It is combinational on count only and does not depend on VALID.
  - On acceptance, the entry is stamped with a 4-bit wrapping sequence number from a shared counter.
  - If both requesters are accepted in the same cycle, ALU gets seq n and MEM gets n+1.
- Drain (one grant per cycle, chosen from the FIFO heads as they stand before this edge's pushes):
  - Neither head valid: WR_EN<=0 next cycle; WR_ADDR and WR_DATA hold.
  - One head valid: that head is granted.
  - Both heads valid with different addresses: round-robin. The grant goes to the pointer side, then the pointer flips to the other side.
  - Both heads valid with equal addresses: the older head wins (smaller seq, compared with wrap-aware modulo-16 subtraction). The pointer is unchanged.
  - The granted entry is popped; WR_EN/WR_ADDR/WR_DATA are registered from it and appear the cycle after the grant.
- Latency and throughput:
  - Minimum latency is 2 posedges: accept at edge N, grant at edge N+1, WR_EN high during cycle N+1..N+2.
  - The register file then commits at its own next edge.
  - Sustained throughput is 1 write/cycle total.
- FIFO boundaries:
  - Push and pop on the same edge of a full FIFO: push is allowed only if READY was high, i.e. count < DEPTH before the edge. No bypass of a full FIFO.
  - A push into an empty FIFO is not grantable in the same cycle.
- STALL:
  - Combinational; high if RD1_ADDR or RD2_ADDR equals the address of any valid FIFO entry, or of the registered write while WR_EN=1.
  - Register 0 is not special.
- PENDING: the count of valid entries in both FIFOs, excluding the registered write stage.
- Sequence numbers: with DEPTH<=4 there are at most 8 live entries, so 4-bit wrap is safe.

Test Plan:
- Reset then single ALU write: ALU_VALID=1, ADDR=3, DATA=0x5A for one cycle -> WR_EN=1, WR_ADDR=3, WR_DATA=0x5A exactly two edges later for one cycle; PENDING 1 then 0.
- Simultaneous different addresses: ALU (2,0x11) and MEM (5,0x22) accepted same edge -> writes ALU then MEM on consecutive cycles; the next contention grants MEM first.
- Same-address ordering: MEM (4,0xAA) accepted, ALU (4,0xBB) one cycle later, both held pending by keeping both FIFOs occupied -> 0xAA written before 0xBB; final reg4=0xBB.
- Backpressure: MEM_VALID held high with 6 back-to-back entries while ALU is also saturated -> MEM_READY=0 when its FIFO holds 2; no entry lost or duplicated; write order per requester preserved.
- Hazard: queue ALU write to r6, drive RD1_ADDR=6 -> STALL=1 until the cycle after WR_EN for r6 deasserts; RD1_ADDR=1 -> STALL=0 throughout.
- Reset mid-operation: 3 entries queued, assert RESET one edge -> WR_EN=0, PENDING=0, STALL=0 next cycle; no queued writes emitted afterwards.
